// File: rtl/spi_reg_file_pkg.sv
// Shared types and constants for the SPI register file: FSM states, error
// counter width and synchroniser depth.
package spi_reg_file_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam int ERR_CNT_W  = 8;
    localparam int SYNC_DEPTH = 2;

endpackage : spi_reg_file_pkg

// File: rtl/spi_sync_edge.sv
// Multi-flop synchroniser with one extra history flop for rise/fall detection
// of an asynchronous input; IDLE_VAL is the level held through reset.
module spi_sync_edge
    import spi_reg_file_pkg::*;
#(
    parameter logic IDLE_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_DEPTH-1:0] sync_q;
    logic                  prev_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {SYNC_DEPTH{IDLE_VAL}};
            prev_q <= IDLE_VAL;
        end else begin
            sync_q <= {sync_q[SYNC_DEPTH-2:0], async_i};
            prev_q <= sync_q[SYNC_DEPTH-1];
        end
    end

    assign sync_o = sync_q[SYNC_DEPTH-1];
    assign rise_o = sync_o & ~prev_q;
    assign fall_o = ~sync_o & prev_q;

endmodule : spi_sync_edge

// File: rtl/spi_reg_file.sv
// SPI-addressed register file with peripheral chip-select/MISO routing.
// Optional register readback on spi_miso is enabled by SPI_REG_FILE_READBACK_EN.
module spi_reg_file
    import spi_reg_file_pkg::*;
#(
    parameter int              DATA_W     = 8,
    parameter int              ADDR_W     = 8,
    parameter int              NUM_REGS   = 4,
    parameter int              NUM_PERIPH = 8,
    parameter int              MUX_ADDR   = 0,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         spi_clk,
    input  logic                         spi_cs,
    input  logic                         spi_special,
    input  logic                         spi_mosi,
    output logic                         spi_miso,
    input  logic [NUM_PERIPH-1:0]        miso_vec,
    output logic [NUM_PERIPH-1:0]        cs_vec,
    output logic [NUM_REGS*DATA_W-1:0]   regs_out,
    output logic                         frame_err,
    output logic [ERR_CNT_W-1:0]         err_count
);

    localparam int FRAME_W  = ADDR_W + DATA_W;
    localparam int BCNT_W   = $clog2(FRAME_W + 2);
    localparam int SETTLE   = SYNC_DEPTH + 1;
    localparam int SETTLE_W = $clog2(SETTLE + 1);

    logic cs_s, cs_rise, cs_fall;
    logic sp_s, sp_rise, sp_fall;
    logic sclk_s, sclk_rise, sclk_fall;
    logic mosi_s, mosi_rise, mosi_fall;

    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_cs (
        .clk(clk), .rst(rst), .async_i(spi_cs),
        .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall)
    );
    spi_sync_edge #(.IDLE_VAL(1'b1)) u_sync_sp (
        .clk(clk), .rst(rst), .async_i(spi_special),
        .sync_o(sp_s), .rise_o(sp_rise), .fall_o(sp_fall)
    );
    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .rst(rst), .async_i(spi_clk),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.IDLE_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .rst(rst), .async_i(spi_mosi),
        .sync_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall)
    );

    state_t                state_q, state_d;
    logic [FRAME_W-1:0]    shift_q, shift_d;
    logic [BCNT_W-1:0]     bitcnt_q, bitcnt_d;
    logic [DATA_W-1:0]     regs_q [NUM_REGS];
    logic [DATA_W-1:0]     regs_d [NUM_REGS];
    logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic                  frame_err_q, frame_err_d;
    logic [SETTLE_W-1:0]   settle_q;
    logic                  armed_q;

    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     data;
    logic                  frame_ok;
    logic                  frame_start;
    logic                  frame_end;
    logic [NUM_PERIPH-1:0] sel;
    logic                  rb_miso;

    assign addr        = shift_q[FRAME_W-1:DATA_W];
    assign data        = shift_q[DATA_W-1:0];
    assign frame_ok    = (bitcnt_q == BCNT_W'(FRAME_W)) && (32'(addr) < NUM_REGS);
    assign frame_start = armed_q && !cs_s && !sp_s && (cs_fall || sp_fall);
    assign frame_end   = cs_rise || sp_rise;

    // A frame already under way when reset releases must not be decoded, so
    // starts are only accepted once chip select has been seen high after settling.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            settle_q <= '0;
            armed_q  <= 1'b0;
        end else begin
            if (settle_q != SETTLE_W'(SETTLE)) begin
                settle_q <= settle_q + 1'b1;
            end else if (cs_s) begin
                armed_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_d     = shift_q;
        bitcnt_d    = bitcnt_q;
        regs_d      = regs_q;
        err_cnt_d   = err_cnt_q;
        frame_err_d = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (frame_start) begin
                    state_d  = ST_SHIFT;
                    shift_d  = '0;
                    bitcnt_d = '0;
                end
            end
            ST_SHIFT: begin
                if (sclk_fall) begin
                    shift_d = {shift_q[FRAME_W-2:0], mosi_s};
                    if (bitcnt_q != BCNT_W'(FRAME_W + 1)) begin
                        bitcnt_d = bitcnt_q + 1'b1;
                    end
                end
                if (frame_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                if (frame_ok) begin
                    for (int n = 0; n < NUM_REGS; n++) begin
                        if (32'(addr) == n) begin
                            regs_d[n] = data;
                        end
                    end
                end else begin
                    frame_err_d = 1'b1;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            shift_q     <= '0;
            bitcnt_q    <= '0;
            err_cnt_q   <= '0;
            frame_err_q <= 1'b0;
            for (int n = 0; n < NUM_REGS; n++) begin
                regs_q[n] <= RESET_VAL;
            end
        end else begin
            state_q     <= state_d;
            shift_q     <= shift_d;
            bitcnt_q    <= bitcnt_d;
            err_cnt_q   <= err_cnt_d;
            frame_err_q <= frame_err_d;
            regs_q      <= regs_d;
        end
    end

    for (genvar n = 0; n < NUM_REGS; n++) begin : g_regs_out
        assign regs_out[n*DATA_W +: DATA_W] = regs_q[n];
    end

    // Select register is zero-extended when narrower than the peripheral count.
    for (genvar i = 0; i < NUM_PERIPH; i++) begin : g_sel
        if (i < DATA_W) begin : g_bit
            assign sel[i] = regs_q[MUX_ADDR][i];
        end else begin : g_zero
            assign sel[i] = 1'b0;
        end
    end

`ifdef SPI_REG_FILE_READBACK_EN
    logic [DATA_W-1:0] rb_q;
    logic              rb_miso_q;
    logic [DATA_W-1:0] rb_sel;

    always_comb begin
        rb_sel = '0;
        for (int n = 0; n < NUM_REGS; n++) begin
            if (shift_q[ADDR_W-1:0] == ADDR_W'(n)) begin
                rb_sel = regs_q[n];
            end
        end
    end

    // Address is complete after ADDR_W falls; the next rising edge starts the data phase.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rb_q      <= '0;
            rb_miso_q <= 1'b0;
        end else if (state_q != ST_SHIFT) begin
            rb_q      <= '0;
            rb_miso_q <= 1'b0;
        end else if (sclk_rise) begin
            if (bitcnt_q == BCNT_W'(ADDR_W)) begin
                rb_miso_q <= rb_sel[DATA_W-1];
                rb_q      <= rb_sel << 1;
            end else begin
                rb_miso_q <= rb_q[DATA_W-1];
                rb_q      <= rb_q << 1;
            end
        end
    end

    assign rb_miso = rb_miso_q;

    logic unused_edges;
    assign unused_edges = ^{sclk_s, mosi_rise, mosi_fall};
`else
    assign rb_miso = 1'b0;

    logic unused_edges;
    assign unused_edges = ^{sclk_s, sclk_rise, mosi_rise, mosi_fall};
`endif

    assign cs_vec    = (!spi_cs && spi_special) ? ~sel : '1;
    assign spi_miso  = spi_special ? |(sel & miso_vec) : rb_miso;
    assign frame_err = frame_err_q;
    assign err_count = err_cnt_q;

endmodule : spi_reg_file
